// File: rtl/key_conditioner_pkg.sv
// Purpose: shared state encoding and default timing constants for the key conditioner.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package key_conditioner_pkg;

  // Per-key debounce FSM states
  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } key_state_t;

  // Board defaults: 20 ms debounce and 1 s long-press at 50 MHz
  localparam int DEF_NUM_KEYS        = 3;
  localparam int DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int DEF_DB_W            = 20;
  localparam int DEF_LONG_CYCLES     = 50000000;
  localparam int DEF_LONG_W          = 26;

endpackage

// File: rtl/key_conditioner_key_debounce_1ch.sv
// Purpose: one key channel; 2-flop synchroniser, debounce FSM, press/release/long pulses and level.
// Latency: press/release pulse DEBOUNCE_CYCLES+2 edges after the pin change is first sampled.
// Backpressure: none; pulses are single-cycle and are never held or queued.
module key_debounce_1ch
  import key_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int DB_W            = DEF_DB_W,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int LONG_W          = DEF_LONG_W
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key_n,
  output logic o_key_level,
  output logic o_key_press,
  output logic o_key_release,
  output logic o_key_long
);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);
  localparam logic [LONG_W-1:0] LONG_MAX  = LONG_W'(LONG_CYCLES);

  logic              r_sync1;
  logic              r_sync2;
  key_state_t        r_state;
  logic [DB_W-1:0]   r_db_cnt;
  logic [LONG_W-1:0] r_long_cnt;
  logic              w_pressed;

  // Pins are active-low; the FSM works with 1 = pressed
  assign w_pressed = ~r_sync2;

  // Two-flop synchroniser; resets to the released level so a held key reads as a new press
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce FSM with counters and registered outputs; pulses default low each cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_db_cnt      <= '0;
      r_long_cnt    <= '0;
      o_key_level   <= 1'b0;
      o_key_press   <= 1'b0;
      o_key_release <= 1'b0;
      o_key_long    <= 1'b0;
    end else begin
      o_key_press   <= 1'b0;
      o_key_release <= 1'b0;
      o_key_long    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pressed) begin
            r_state  <= ST_PRESS_WAIT;
            r_db_cnt <= '0;
          end
        end
        ST_PRESS_WAIT: begin
          if (!w_pressed) begin
            r_state <= ST_IDLE;
          end else if (r_db_cnt == DB_LAST) begin
            r_state     <= ST_HELD;
            o_key_press <= 1'b1;
            o_key_level <= 1'b1;
            r_long_cnt  <= '0;
          end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
          end
        end
        ST_HELD: begin
          // Saturation guarantees the LONG_LAST match happens only once per press,
          // even across rejected release glitches that return here
          if (r_long_cnt != LONG_MAX) begin
            r_long_cnt <= r_long_cnt + 1'b1;
          end
          if (r_long_cnt == LONG_LAST) begin
            o_key_long <= 1'b1;
          end
          if (!w_pressed) begin
            r_state  <= ST_RELEASE_WAIT;
            r_db_cnt <= '0;
          end
        end
        ST_RELEASE_WAIT: begin
          if (w_pressed) begin
            r_state <= ST_HELD;
          end else if (r_db_cnt == DB_LAST) begin
            r_state       <= ST_IDLE;
            o_key_release <= 1'b1;
            o_key_level   <= 1'b0;
          end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/key_conditioner.sv
// Purpose: conditions NUM_KEYS raw active-low push-buttons into clean level and event pulses.
// Latency: press/release pulse DEBOUNCE_CYCLES+2 edges after a stable pin change; long pulse LONG_CYCLES after press.
// Backpressure: none; channels are independent and may pulse in the same cycle.
module key_conditioner
  import key_conditioner_pkg::*;
#(
  parameter int NUM_KEYS        = DEF_NUM_KEYS,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int DB_W            = DEF_DB_W,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int LONG_W          = DEF_LONG_W
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NUM_KEYS-1:0] i_key_n,
  output logic [NUM_KEYS-1:0] o_key_level,
  output logic [NUM_KEYS-1:0] o_key_press,
  output logic [NUM_KEYS-1:0] o_key_release,
  output logic [NUM_KEYS-1:0] o_key_long
);

  // One self-contained channel per key; no cross-channel logic
  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    key_debounce_1ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .DB_W            (DB_W),
      .LONG_CYCLES     (LONG_CYCLES),
      .LONG_W          (LONG_W)
    ) u_ch (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_key_n       (i_key_n[g]),
      .o_key_level   (o_key_level[g]),
      .o_key_press   (o_key_press[g]),
      .o_key_release (o_key_release[g]),
      .o_key_long    (o_key_long[g])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Purpose: directed self-checking bench for key_conditioner with short debounce/long timings.
// Latency: expects pulses 6 cycles after a stable edge (DEBOUNCE_CYCLES=4) and long 10 cycles after press.
// Backpressure: n/a.
module tb_key_conditioner;

  logic       clk;
  logic       rst_n;
  logic [2:0] key_n;
  logic [2:0] key_level;
  logic [2:0] key_press;
  logic [2:0] key_release;
  logic [2:0] key_long;

  int n_total = 0;
  int n_bad   = 0;

  key_conditioner #(
    .NUM_KEYS        (3),
    .DEBOUNCE_CYCLES (4),
    .DB_W            (3),
    .LONG_CYCLES     (10),
    .LONG_W          (4)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_key_n       (key_n),
    .o_key_level   (key_level),
    .o_key_press   (key_press),
    .o_key_release (key_release),
    .o_key_long    (key_long)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    key_n = 3'b111;
    #3;
    chk("rst_level",   8'(key_level),   8'h0);
    chk("rst_press",   8'(key_press),   8'h0);
    chk("rst_release", 8'(key_release), 8'h0);
    chk("rst_long",    8'(key_long),    8'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // 1: clean press on key 0, no long-press
    for (int c = 0; c < 8; c++) begin
      key_n[0] = 1'b0;
      tick();
      chk("t1_press", 8'(key_press), (c == 6) ? 8'h1 : 8'h0);
      chk("t1_level", 8'(key_level), (c >= 6) ? 8'h1 : 8'h0);
      chk("t1_long",  8'(key_long),  8'h0);
    end
    for (int c = 0; c < 8; c++) begin
      key_n[0] = 1'b1;
      tick();
      chk("t1_release", 8'(key_release), (c == 6) ? 8'h1 : 8'h0);
      chk("t1_rlevel",  8'(key_level),   (c < 6) ? 8'h1 : 8'h0);
      chk("t1_rlong",   8'(key_long),    8'h0);
    end
    repeat (3) tick();

    // 2: bounce on key 1 rejected, stable press accepted at cycle 10
    for (int c = 0; c < 13; c++) begin
      key_n[1] = (c == 3) ? 1'b1 : 1'b0;
      tick();
      chk("t2_press", 8'(key_press), (c == 10) ? 8'h2 : 8'h0);
      chk("t2_level", 8'(key_level), (c >= 10) ? 8'h2 : 8'h0);
    end
    for (int c = 0; c < 8; c++) begin
      key_n[1] = 1'b1;
      tick();
      chk("t2_release", 8'(key_release), (c == 6) ? 8'h2 : 8'h0);
    end
    repeat (3) tick();

    // 3: key 0 held, 2-cycle release glitch rejected, then real release
    for (int c = 0; c < 7; c++) begin
      key_n[0] = 1'b0;
      tick();
      chk("t3_press", 8'(key_press), (c == 6) ? 8'h1 : 8'h0);
    end
    for (int c = 0; c < 10; c++) begin
      key_n[0] = (c < 2) ? 1'b1 : 1'b0;
      tick();
      chk("t3_g_release", 8'(key_release), 8'h0);
      chk("t3_g_press",   8'(key_press),   8'h0);
      chk("t3_g_level",   8'(key_level),   8'h1);
    end
    for (int c = 0; c < 8; c++) begin
      key_n[0] = 1'b1;
      tick();
      chk("t3_release", 8'(key_release), (c == 6) ? 8'h1 : 8'h0);
      chk("t3_rlevel",  8'(key_level),   (c < 6) ? 8'h1 : 8'h0);
    end
    repeat (3) tick();

    // 4: key 2 held 30 cycles: press at 6, single long at 16
    for (int c = 0; c < 30; c++) begin
      key_n[2] = 1'b0;
      tick();
      chk("t4_press",   8'(key_press),   (c == 6) ? 8'h4 : 8'h0);
      chk("t4_long",    8'(key_long),    (c == 16) ? 8'h4 : 8'h0);
      chk("t4_release", 8'(key_release), 8'h0);
    end
    for (int c = 0; c < 8; c++) begin
      key_n[2] = 1'b1;
      tick();
      chk("t4_rrelease", 8'(key_release), (c == 6) ? 8'h4 : 8'h0);
      chk("t4_rlong",    8'(key_long),    8'h0);
    end
    repeat (3) tick();

    // 5: keys 0 and 2 together pulse together
    for (int c = 0; c < 8; c++) begin
      key_n = 3'b010;
      tick();
      chk("t5_press", 8'(key_press), (c == 6) ? 8'h5 : 8'h0);
      chk("t5_level", 8'(key_level), (c >= 6) ? 8'h5 : 8'h0);
    end
    for (int c = 0; c < 8; c++) begin
      key_n = 3'b111;
      tick();
      chk("t5_release", 8'(key_release), (c == 6) ? 8'h5 : 8'h0);
    end
    repeat (3) tick();

    // 6: reset while key 0 is HELD, then re-press after reset release
    for (int c = 0; c < 9; c++) begin
      key_n[0] = 1'b0;
      tick();
      chk("t6_press", 8'(key_press), (c == 6) ? 8'h1 : 8'h0);
    end
    chk("t6_prelevel", 8'(key_level), 8'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_level", 8'(key_level), 8'h0);
    chk("t6_rst_press", 8'(key_press), 8'h0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("t6_repress", 8'(key_press), (c == 6) ? 8'h1 : 8'h0);
      chk("t6_relevel", 8'(key_level), (c >= 6) ? 8'h1 : 8'h0);
      chk("t6_relong",  8'(key_long),  8'h0);
    end
    key_n[0] = 1'b1;
    repeat (10) tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
